mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 Parameter MEM_LIMIT, default 32'd64, highest valid byte address of the attached ram.
- REQ-002 clk  input  1  single clock; all state updates on posedge clk.
- REQ-003 reset  input  1  reset is synchronous and active-high.
- REQ-004 req  input  2  per-requester request; bit0 = instruction port, bit1 = data port.
- REQ-005 wr  input  2  per-requester 1 = write, 0 = read.
- REQ-006 word  input  2  per-requester 1 = full word (4 bytes), 0 = half word (2 bytes).
- REQ-007 sign  input  2  per-requester half-word read extension; 1 = signed, 0 = unsigned.
- REQ-008 addr  input  64  packed byte addresses; [31:0] is port 0, [63:32] is port 1.
- REQ-009 wdata  input  64  packed write data, packed the same way as addr.
- REQ-010 ack  output  2  one-cycle completion pulse for the served port.
- REQ-011 err  output  2  error flag, valid only in the cycle its ack bit is high.
- REQ-012 rdata  output  32  registered read data, valid with a read ack.
- REQ-013 mem_address, mem_dataIn  output  32 each  drive the ram address and write-data ports.
- REQ-014 mem_write, mem_read, mem_word, mem_sign  output  1 each  ram control strobes and size/sign selects.
- REQ-015 mem_dataOut  input  32  ram read data.

Function
- REQ-016 FSM states: IDLE, ACCESS, RESP; there is exactly one transaction in flight.
- REQ-017 IDLE with req != 0: latch winner index, wr, word, sign, addr and wdata into command registers.
  - If the command is legal, the next state is ACCESS.
  - If it is illegal, the next state is RESP with err pending.
- REQ-018 Illegal command, any of:
  - word=1 and addr[1:0] != 0;
  - word=0 and addr[0] != 0;
  - addr + (word ? 3 : 1) > MEM_LIMIT, computed in 33 bits so wrap-around counts as out of range.
- REQ-019 ACCESS lasts one cycle:
  - mem_read = !wr and mem_write = wr, driven from registered state;
  - mem_address, mem_dataIn, mem_word and mem_sign come from the command registers;
  - rdata captures mem_dataOut on the closing edge when the command is a read.
- REQ-020 RESP lasts one cycle: ack[winner] = 1 and err[winner] = error flag; then the next state is IDLE.
- REQ-021 Strobe rules outside ACCESS:
  - mem_write and mem_read are 0 in every state except ACCESS;
  - an illegal command never asserts either strobe.
- REQ-022 Latency: a request sampled at edge N acks in the cycle after edge N+2 (3 cycles per transaction); an illegal command acks in the cycle after edge N+1.
- REQ-023 Requester handshake:
  - hold req and all fields stable until ack;
  - drop req in the cycle after ack unless a new request is presented;
  - req is ignored in ACCESS and RESP.
- REQ-024 rdata holds its value until the next read ACCESS; it is unchanged by writes and errors.
- REQ-025 When both req bits are high in IDLE, the winner follows the priority policy in REQ-029.

Reset
- REQ-026 reset has priority over all transitions and is sampled on the clock edge: state goes to IDLE, and ack, err, mem_write, mem_read and rdata are all 0 after the edge.
- REQ-027 Reset asserted during ACCESS: the ram write already presented at that edge completes, and no ack is issued for it.
- REQ-028 The round-robin last-grant register resets to 1, so port 0 wins the first tie.

Configuration
- REQ-029 Macro MEM_ARB_RR_EN selects the tie-break policy:
  - defined: round-robin; on a tie the port not served last wins, and the last-grant register updates on every grant, including errors;
  - undefined: fixed priority; the data port (bit1) always wins a tie, and no last-grant register is built.

Structure
- REQ-030 Shared package mem_arb_pkg holds:
  - state encoding constants: IDLE, ACCESS, RESP;
  - port indices: PORT_IF = 0, PORT_DATA = 1;
  - the default MEM_LIMIT value.
- REQ-031 One sub-module, mem_arb_pick: combinational winner selection from req and the last-grant register, with the policy chosen by MEM_ARB_RR_EN.

Verification
- REQ-032 Port 1 write then read:
  - stimulus: port 1 write word=1, addr=24, wdata=F00FF176; then port 1 read word=1, addr=24;
  - required: the write acks with err=0; the read acks with rdata=F00FF176, 3 cycles after req.
- REQ-033 Half-word reads of the stored value at addr=24:
  - stimulus: read with word=0, sign=1; then with word=0, sign=0;
  - required: rdata=FFFFF176 for the signed read; rdata=0000F176 for the unsigned read.
- REQ-034 Illegal commands:
  - stimulus: read word=1, addr=26; then write word=1, addr=62;
  - required: each acks with err=1 after 2 cycles; mem_write and mem_read never assert; memory is unchanged.
- REQ-035 Simultaneous requests, both req bits held high for 4 transactions:
  - with MEM_ARB_RR_EN: grants alternate 0, 1, 0, 1;
  - without it: all four go to port 1 while port 1 keeps re-requesting.
- REQ-036 Reset mid-operation:
  - stimulus: reset pulsed during ACCESS of a port 0 write;
  - required: no ack; state is IDLE next cycle; the written location holds the new data.
- REQ-037 Back-to-back stability: port 0 keeps req high after ack with a new addr; the second transaction is served and no transaction is duplicated.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, port indices and command legality check for mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          PORT_IF           = 0;
  localparam int          PORT_DATA         = 1;
  localparam logic [31:0] MEM_LIMIT_DEFAULT = 32'd64;

  // End address is formed in 33 bits so a wrapped access is rejected, not aliased.
  function automatic logic cmd_illegal(input logic word, input logic [31:0] addr,
                                       input logic [31:0] limit);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + (word ? 33'd3 : 33'd1);
    return (word && (addr[1:0] != 2'b00)) || (!word && addr[0]) ||
           (last_byte > {1'b0, limit});
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the instruction and data ports.
// MEM_ARB_RR_EN: round-robin tie-break; default build: data port has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic       last,
`endif
  output logic       grant
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant = req[PORT_DATA];
    if (req[PORT_IF] && req[PORT_DATA]) grant = ~last;
  end
`else
  always_comb grant = req[PORT_DATA] || !req[PORT_IF];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter with one transaction in flight (IDLE -> ACCESS -> RESP).
// Tie-break policy is selected by MEM_ARB_RR_EN (round-robin) or fixed priority by default.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT = MEM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  wr,
  input  logic [1:0]  word,
  input  logic [1:0]  sign,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  output logic        mem_write,
  output logic        mem_read,
  output logic        mem_word,
  output logic        mem_sign,
  input  logic [31:0] mem_dataOut
);

  // state  | meaning
  // IDLE   | waiting for a request; latches the winner's command
  // ACCESS | ram strobe cycle; read data captured on the closing edge
  // RESP   | schedules the ack/err pulse for the winning port

  state_t      state;
  logic        grant;
  logic        sel_wr, sel_word, sel_sign, sel_bad;
  logic [31:0] sel_addr, sel_wdata;
  logic        cmd_port, cmd_wr, cmd_word, cmd_sign, cmd_err;
  logic [31:0] cmd_addr, cmd_wdata;
`ifdef MEM_ARB_RR_EN
  logic        last_grant;
`endif

  mem_arb_pick u_pick (
    .req   (req),
`ifdef MEM_ARB_RR_EN
    .last  (last_grant),
`endif
    .grant (grant)
  );

  always_comb begin
    sel_wr    = wr[grant];
    sel_word  = word[grant];
    sel_sign  = sign[grant];
    sel_addr  = grant ? addr[63:32]  : addr[31:0];
    sel_wdata = grant ? wdata[63:32] : wdata[31:0];
    sel_bad   = cmd_illegal(sel_word, sel_addr, MEM_LIMIT);
  end

  assign mem_address = cmd_addr;
  assign mem_dataIn  = cmd_wdata;
  assign mem_word    = cmd_word;
  assign mem_sign    = cmd_sign;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ack       <= 2'b00;
      err       <= 2'b00;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      rdata     <= 32'd0;
      cmd_port  <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_word  <= 1'b0;
      cmd_sign  <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_addr  <= 32'd0;
      cmd_wdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack <= 2'b00;
      err <= 2'b00;
      case (state)
        IDLE: begin
          // During the ack cycle req still shows the request just completed.
          if (req != 2'b00 && ack == 2'b00) begin
            cmd_port  <= grant;
            cmd_wr    <= sel_wr;
            cmd_word  <= sel_word;
            cmd_sign  <= sel_sign;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            cmd_err   <= sel_bad;
`ifdef MEM_ARB_RR_EN
            last_grant <= grant;
`endif
            if (sel_bad) begin
              state <= RESP;
            end else begin
              state     <= ACCESS;
              mem_write <= sel_wr;
              mem_read  <= !sel_wr;
            end
          end
        end
        ACCESS: begin
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if (!cmd_wr) rdata <= mem_dataOut;
          state <= RESP;
        end
        RESP: begin
          ack[cmd_port] <= 1'b1;
          err[cmd_port] <= cmd_err;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, tie/reset/back-to-back sequences,
// and randomized traffic against a byte-level memory model.
module tb_mem_arbiter;

  localparam int MEM_LIMIT = 64;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr, word, sign;
  logic [63:0] addr, wdata;
  logic [1:0]  ack, err;
  logic [31:0] rdata, mem_address, mem_dataIn, mem_dataOut;
  logic        mem_write, mem_read, mem_word, mem_sign;

  logic [7:0]  ram       [0:255];
  logic [7:0]  model_mem [0:255];
  logic [31:0] model_rdata;
  logic        last_grant;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .word(word), .sign(sign),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_write(mem_write),
    .mem_read(mem_read), .mem_word(mem_word), .mem_sign(mem_sign),
    .mem_dataOut(mem_dataOut)
  );

  // Little-endian byte ram; half-word reads are extended by the ram itself.
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_address[7:0]]         <= mem_dataIn[7:0];
      ram[mem_address[7:0] + 8'd1]  <= mem_dataIn[15:8];
      if (mem_word) begin
        ram[mem_address[7:0] + 8'd2] <= mem_dataIn[23:16];
        ram[mem_address[7:0] + 8'd3] <= mem_dataIn[31:24];
      end
    end
  end

  always_comb begin
    logic [7:0]  ra;
    logic [15:0] h;
    ra = mem_address[7:0];
    h  = {ram[ra + 8'd1], ram[ra]};
    if (mem_word)      mem_dataOut = {ram[ra + 8'd3], ram[ra + 8'd2], h};
    else if (mem_sign) mem_dataOut = {{16{h[15]}}, h};
    else               mem_dataOut = {16'h0000, h};
  end

  function automatic logic [1:0] oh(input int p);
    return 2'b01 << p;
  endfunction

  function automatic bit model_illegal(input bit wd, input logic [31:0] a);
    longint unsigned last_byte;
    last_byte = longint'(a) + (wd ? 3 : 1);
    return (wd && (a % 4 != 0)) || (!wd && (a % 2 != 0)) || (last_byte > MEM_LIMIT);
  endfunction

  function automatic logic [31:0] model_read(input bit wd, input bit sg, input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < (wd ? 4 : 2); i++) v[8*i +: 8] = model_mem[8'(a + i)];
    if (!wd && sg && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transaction on port p; lat_adj covers requests presented right after an ack edge.
  task automatic txn(input int p, input bit w, input bit wd, input bit sg,
                     input logic [31:0] a, input logic [31:0] d, input bit exp_err,
                     input logic [31:0] exp_rd, input int lat_adj, input bit keep,
                     input string nm);
    int         cyc;
    bit         saw;
    logic [1:0] seen;
    wr[p] = w; word[p] = wd; sign[p] = sg;
    addr[p*32 +: 32] = a; wdata[p*32 +: 32] = d; req[p] = 1'b1;
    cyc = 0; saw = 1'b0;
    while (ack == 2'b00 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_write || mem_read) saw = 1'b1;
    end
    if (!exp_err && w)
      for (int i = 0; i < (wd ? 4 : 2); i++) model_mem[8'(a + i)] = d[8*i +: 8];
    if (!exp_err && !w) model_rdata = exp_rd;
    last_grant = p[0];
    chk({nm, " ack"}, 32'(ack), 32'(oh(p)));
    chk({nm, " err"}, 32'(err), exp_err ? 32'(oh(p)) : 32'd0);
    chk({nm, " latency"}, 32'(cyc), 32'((exp_err ? 2 : 3) + lat_adj));
    chk({nm, " rdata"}, rdata, model_rdata);
    if (exp_err) chk({nm, " strobe"}, 32'(saw), 32'd0);
    @(posedge clk); #1;
    if (!keep) begin
      req[p] = 1'b0;
      seen = 2'b00;
      repeat (4) begin
        @(negedge clk);
        seen |= ack;
      end
      chk({nm, " no_dup"}, 32'(seen), 32'd0);
    end
  endtask

  typedef struct {
    int          p;
    bit          w;
    bit          wd;
    bit          sg;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  seen;
    logic [31:0] d0, d1, exp_rd;
    logic        win;
    int          cyc, p;
    bit          w, wd, sg, e;
    logic [31:0] a, d;

    tbl[0]  = '{1, 1'b1, 1'b1, 1'b0, 32'd24,         32'hF00FF176, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b0, 1'b1, 1'b0, 32'd24,         32'h0,        1'b0, 32'hF00FF176};
    tbl[2]  = '{1, 1'b0, 1'b0, 1'b1, 32'd24,         32'h0,        1'b0, 32'hFFFFF176};
    tbl[3]  = '{1, 1'b0, 1'b0, 1'b0, 32'd24,         32'h0,        1'b0, 32'h0000F176};
    tbl[4]  = '{0, 1'b0, 1'b1, 1'b0, 32'd26,         32'h0,        1'b1, 32'h0};
    tbl[5]  = '{1, 1'b1, 1'b1, 1'b0, 32'd62,         32'hDEADBEEF, 1'b1, 32'h0};
    tbl[6]  = '{0, 1'b0, 1'b0, 1'b0, 32'd63,         32'h0,        1'b1, 32'h0};
    tbl[7]  = '{0, 1'b1, 1'b0, 1'b0, 32'd62,         32'h0000ABCD, 1'b0, 32'h0};
    tbl[8]  = '{0, 1'b0, 1'b0, 1'b0, 32'd62,         32'h0,        1'b0, 32'h0000ABCD};
    tbl[9]  = '{0, 1'b1, 1'b1, 1'b0, 32'd60,         32'h12345678, 1'b0, 32'h0};
    tbl[10] = '{1, 1'b0, 1'b1, 1'b0, 32'd60,         32'h0,        1'b0, 32'h12345678};
    tbl[11] = '{0, 1'b0, 1'b0, 1'b0, 32'd64,         32'h0,        1'b1, 32'h0};
    tbl[12] = '{1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFC,   32'h0,        1'b1, 32'h0};

    for (int i = 0; i < 256; i++) begin
      ram[i]       = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    reset = 1'b1; req = 2'b00; wr = 2'b00; word = 2'b00; sign = 2'b00;
    addr = 64'd0; wdata = 64'd0;
    model_rdata = 32'd0; last_grant = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset strobes", 32'({mem_write, mem_read}), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      txn(tbl[i].p, tbl[i].w, tbl[i].wd, tbl[i].sg, tbl[i].a, tbl[i].d, tbl[i].exp_err,
          tbl[i].exp_rd, 0, 1'b0, $sformatf("vec%0d", i));

    // Back-to-back requests from port 0 without dropping req.
    txn(0, 1'b1, 1'b1, 1'b0, 32'd40, 32'hA5A5_0001, 1'b0, 32'h0, 0, 1'b1, "b2b w40");
    txn(0, 1'b1, 1'b1, 1'b0, 32'd44, 32'h5A5A_0002, 1'b0, 32'h0, 1, 1'b1, "b2b w44");
    txn(0, 1'b0, 1'b1, 1'b0, 32'd40, 32'h0, 1'b0, 32'hA5A5_0001, 1, 1'b1, "b2b r40");
    txn(0, 1'b0, 1'b1, 1'b0, 32'd44, 32'h0, 1'b0, 32'h5A5A_0002, 1, 1'b0, "b2b r44");

    // Both ports hold req high for four transactions.
    wr = 2'b00; word = 2'b11; sign = 2'b00; addr = {32'd4, 32'd0};
    d0 = model_read(1'b1, 1'b0, 32'd0);
    d1 = model_read(1'b1, 1'b0, 32'd4);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      cyc = 0;
      while (ack == 2'b00 && cyc < 12) begin
        @(negedge clk);
        cyc++;
      end
      win = RR_MODE ? !last_grant : 1'b1;
      model_rdata = win ? d1 : d0;
      chk($sformatf("tie%0d grant", t), 32'(ack), 32'(oh(int'(win))));
      chk($sformatf("tie%0d rdata", t), rdata, model_rdata);
      last_grant = win;
      @(negedge clk);
    end
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Reset pulsed during the ACCESS cycle of a port 0 write.
    wr[0] = 1'b1; word[0] = 1'b1; sign[0] = 1'b0;
    addr[31:0] = 32'd8; wdata[31:0] = 32'hCAFEBABE; req[0] = 1'b1;
    @(negedge clk);
    chk("rst mid write strobe", 32'(mem_write), 32'd1);
    reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst strobes", 32'({mem_write, mem_read}), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst ram written", {ram[11], ram[10], ram[9], ram[8]}, 32'hCAFEBABE);
    for (int i = 0; i < 4; i++) model_mem[8 + i] = 8'(32'hCAFEBABE >> (8 * i));
    model_rdata = 32'd0; last_grant = 1'b1;
    seen = 2'b00;
    repeat (4) begin
      @(negedge clk);
      seen |= ack;
    end
    chk("rst no ack", 32'(seen), 32'd0);
    txn(0, 1'b0, 1'b1, 1'b0, 32'd8, 32'h0, 1'b0, model_read(1'b1, 1'b0, 32'd8), 0, 1'b0,
        "rst readback");

    // Randomized single-port traffic, legal and illegal.
    for (int n = 0; n < 40; n++) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 70));
      if ($urandom_range(0, 3) != 0) a = wd ? (a & ~32'd3) : (a & ~32'd1);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      d  = $urandom;
      e  = model_illegal(wd, a);
      exp_rd = model_read(wd, sg, a);
      txn(p, w, wd, sg, a, d, e, exp_rd, 0, 1'b0, $sformatf("rnd%0d", n));
    end

    seen = 2'b00;
    for (int i = 0; i < 72; i++) if (ram[i] !== model_mem[i]) seen = 2'b01;
    chk("memory image", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
